// File: rtl/cordic_vectoring.sv
// rtl/cordic_vectoring.sv - iterative vectoring-mode CORDIC: (X, Y) -> atan2 angle and compensated magnitude, Q.18
module cordic_vectoring #(
  parameter int DATA_W = 20,
  parameter int ITER   = 19,
  parameter int INT_W  = 23
) (
  input  logic                     CLK_I,
  input  logic                     RST_N_I,
  input  logic signed [DATA_W-1:0] X_I,
  input  logic signed [DATA_W-1:0] Y_I,
  input  logic                     READY_I,
  output logic signed [31:0]       ANGLE_O,
  output logic signed [31:0]       MAG_O,
  output logic                     BUSY_O,
  output logic                     DONE_O
);

  localparam int Z_W = 22;
  localparam logic signed [Z_W-1:0] HALF_PI  = 22'sd411775;
  localparam logic signed [18:0]    INV_GAIN = 19'sd159188;

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_ITER, S_SCALE} state_t;

  state_t                   state, nxt;
  logic signed [INT_W-1:0]  x, y;
  logic signed [Z_W-1:0]    z;
  logic [4:0]               i;
  logic                     zero;
  logic                     last_iter;
  logic signed [INT_W+18:0] prod, prod_sh;

  function automatic logic signed [Z_W-1:0] atan_lut(input logic [4:0] k);
    case (k)
      5'd0:    atan_lut = 22'sd205887;
      5'd1:    atan_lut = 22'sd121542;
      5'd2:    atan_lut = 22'sd64220;
      5'd3:    atan_lut = 22'sd32599;
      5'd4:    atan_lut = 22'sd16363;
      5'd5:    atan_lut = 22'sd8189;
      5'd6:    atan_lut = 22'sd4096;
      5'd7:    atan_lut = 22'sd2048;
      5'd8:    atan_lut = 22'sd1024;
      5'd9:    atan_lut = 22'sd512;
      5'd10:   atan_lut = 22'sd256;
      5'd11:   atan_lut = 22'sd128;
      5'd12:   atan_lut = 22'sd64;
      5'd13:   atan_lut = 22'sd32;
      5'd14:   atan_lut = 22'sd16;
      5'd15:   atan_lut = 22'sd8;
      5'd16:   atan_lut = 22'sd4;
      5'd17:   atan_lut = 22'sd2;
      5'd18:   atan_lut = 22'sd1;
      default: atan_lut = 22'sd0;
    endcase
  endfunction

  assign last_iter = (i == 5'(ITER - 1));
  assign prod      = x * INV_GAIN;
  assign prod_sh   = prod >>> 18;

  always_ff @(posedge CLK_I or posedge RST_N_I) begin
    if (RST_N_I) state <= S_IDLE;
    else         state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (READY_I) nxt = S_PRE;
      S_PRE:   nxt = S_ITER;
      S_ITER:  if (last_iter) nxt = S_SCALE;
      S_SCALE: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    BUSY_O = (state != S_IDLE);
  end

  always_ff @(posedge CLK_I or posedge RST_N_I) begin
    if (RST_N_I) begin
      x       <= '0;
      y       <= '0;
      z       <= '0;
      i       <= '0;
      zero    <= 1'b0;
      ANGLE_O <= '0;
      MAG_O   <= '0;
      DONE_O  <= 1'b0;
    end else begin
      DONE_O <= (state == S_SCALE);
      case (state)
        S_IDLE: begin
          if (READY_I) begin
            x <= INT_W'(X_I);
            y <= INT_W'(Y_I);
            i <= '0;
          end
        end
        S_PRE: begin
          zero <= (x == '0) && (y == '0);
          // Fold the left half-plane into the right so the micro-rotations converge
          if (!x[INT_W-1]) begin
            z <= '0;
          end else if (!y[INT_W-1]) begin
            x <= y;
            y <= -x;
            z <= HALF_PI;
          end else begin
            x <= -y;
            y <= x;
            z <= -HALF_PI;
          end
        end
        S_ITER: begin
          if (!y[INT_W-1]) begin
            x <= x + (y >>> i);
            y <= y - (x >>> i);
            z <= z + atan_lut(i);
          end else begin
            x <= x - (y >>> i);
            y <= y + (x >>> i);
            z <= z - atan_lut(i);
          end
          i <= i + 5'd1;
        end
        S_SCALE: begin
          if (zero) begin
            ANGLE_O <= '0;
            MAG_O   <= '0;
          end else begin
            ANGLE_O <= 32'(z);
            MAG_O   <= 32'(prod_sh);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vectoring.sv
// tb/tb_cordic_vectoring.sv - self-checking bench for cordic_vectoring against an ideal atan2/hypot model
module tb_cordic_vectoring;

  logic               CLK_I = 1'b0;
  logic               RST_N_I = 1'b1;
  logic signed [19:0] X_I = '0;
  logic signed [19:0] Y_I = '0;
  logic               READY_I = 1'b0;
  logic signed [31:0] ANGLE_O, MAG_O;
  logic               BUSY_O, DONE_O;

  int total = 0;
  int bad   = 0;

  cordic_vectoring dut (
    .CLK_I  (CLK_I),
    .RST_N_I(RST_N_I),
    .X_I    (X_I),
    .Y_I    (Y_I),
    .READY_I(READY_I),
    .ANGLE_O(ANGLE_O),
    .MAG_O  (MAG_O),
    .BUSY_O (BUSY_O),
    .DONE_O (DONE_O)
  );

  always #5 CLK_I = ~CLK_I;

  task automatic check(input string tag, input longint obs, input longint exp, input longint tol);
    longint d;
    total++;
    d = obs - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  function automatic longint ideal_angle(input longint xv, input longint yv);
    real a;
    if (xv == 0 && yv == 0) return 0;
    a = $atan2(real'(yv), real'(xv)) * 262144.0;
    return longint'(a);
  endfunction

  function automatic longint ideal_mag(input longint xv, input longint yv);
    real m;
    m = $sqrt(real'(xv) * real'(xv) + real'(yv) * real'(yv));
    return longint'(m);
  endfunction

  // Called away from a clock edge; returns #1 after the accepting edge with READY_I low.
  task automatic start_op(input longint xv, input longint yv);
    X_I = 20'(xv);
    Y_I = 20'(yv);
    READY_I = 1'b1;
    @(posedge CLK_I);
    #1;
    READY_I = 1'b0;
  endtask

  task automatic wait_done(input int n0, output int n, output int busy);
    n = n0;
    busy = BUSY_O ? 1 : 0;
    while (!DONE_O && n < 100) begin
      @(posedge CLK_I);
      #1;
      n++;
      if (BUSY_O) busy++;
    end
  endtask

  task automatic check_result(input string tag, input longint xv, input longint yv);
    check({tag, "_angle"}, longint'(ANGLE_O), ideal_angle(xv, yv), 16);
    check({tag, "_mag"},   longint'(MAG_O),   ideal_mag(xv, yv),   32);
  endtask

  task automatic full_op(input string tag, input longint xv, input longint yv);
    int n, busy;
    start_op(xv, yv);
    wait_done(0, n, busy);
    check({tag, "_latency"}, n, 21, 0);
    check_result(tag, xv, yv);
    @(posedge CLK_I);
    #1;
    check({tag, "_done_pulse"}, DONE_O, 0, 0);
  endtask

  initial begin
    int n, busy;
    longint rx, ry;
    real mag;

    #12;
    check("rst_angle", ANGLE_O, 0, 0);
    check("rst_mag",   MAG_O,   0, 0);
    check("rst_busy",  BUSY_O,  0, 0);
    check("rst_done",  DONE_O,  0, 0);
    @(negedge CLK_I);
    RST_N_I = 1'b0;
    @(negedge CLK_I);

    // Unit vector along +x, with latency and busy window
    start_op(262144, 0);
    wait_done(0, n, busy);
    check("t1_latency", n, 21, 0);
    check("t1_busy_cycles", busy, 21, 0);
    check("t1_angle", ANGLE_O, 0, 16);
    check("t1_mag", MAG_O, 262144, 32);
    @(posedge CLK_I);
    #1;
    check("t1_done_pulse", DONE_O, 0, 0);

    full_op("north", 0, 262144);
    check("north_spec", ANGLE_O, 411775, 16);
    full_op("west", -262144, 0);
    check("west_spec_angle", ANGLE_O, 823550, 16);
    check("west_spec_mag", MAG_O, 262144, 32);
    full_op("south", 0, -262144);
    check("south_spec", ANGLE_O, -411775, 16);
    full_op("sw", -185364, -185364);
    check("sw_spec_angle", ANGLE_O, -617663, 16);
    full_op("fullscale", -524288, -524288);
    check("fullscale_spec_angle", ANGLE_O, -617663, 16);
    check("fullscale_spec_mag", MAG_O, 741455, 32);

    start_op(0, 0);
    wait_done(0, n, busy);
    check("zero_latency", n, 21, 0);
    check("zero_angle", ANGLE_O, 0, 0);
    check("zero_mag", MAG_O, 0, 0);
    @(posedge CLK_I);
    #1;
    check("zero_done_pulse", DONE_O, 0, 0);

    // Back-to-back: new start raised while DONE_O is high
    start_op(200000, 100000);
    wait_done(0, n, busy);
    check("b2b_a_latency", n, 21, 0);
    check_result("b2b_a", 200000, 100000);
    start_op(-150000, 300000);
    check("b2b_done_drop", DONE_O, 0, 0);
    check("b2b_busy", BUSY_O, 1, 0);
    wait_done(0, n, busy);
    check("b2b_b_latency", n, 21, 0);
    check_result("b2b_b", -150000, 300000);

    // Start request mid-operation must be ignored
    start_op(300000, -50000);
    repeat (5) @(posedge CLK_I);
    #1;
    X_I = 20'sd100;
    Y_I = 20'sd100000;
    READY_I = 1'b1;
    @(posedge CLK_I);
    #1;
    READY_I = 1'b0;
    X_I = -20'sd77777;
    wait_done(6, n, busy);
    check("ign_latency", n, 21, 0);
    check_result("ign", 300000, -50000);
    @(posedge CLK_I);
    #1;
    check("ign_no_second", BUSY_O, 0, 0);

    // Reset during iteration 10
    start_op(-100000, 200000);
    repeat (11) @(posedge CLK_I);
    #1;
    RST_N_I = 1'b1;
    #1;
    check("midrst_angle", ANGLE_O, 0, 0);
    check("midrst_mag", MAG_O, 0, 0);
    check("midrst_busy", BUSY_O, 0, 0);
    check("midrst_done", DONE_O, 0, 0);
    @(negedge CLK_I);
    RST_N_I = 1'b0;
    n = 0;
    repeat (30) begin
      @(posedge CLK_I);
      #1;
      if (DONE_O) n++;
    end
    check("midrst_no_done", n, 0, 0);
    full_op("post_rst", 262144, 262144);
    check("post_rst_spec_angle", ANGLE_O, 205887, 16);
    check("post_rst_spec_mag", MAG_O, 370727, 32);

    // Random vectors with magnitude large enough for the stated angle accuracy
    for (int k = 0; k < 16; k++) begin
      do begin
        rx = longint'($urandom_range(0, 1048575)) - 524288;
        ry = longint'($urandom_range(0, 1048575)) - 524288;
        mag = $sqrt(real'(rx) * real'(rx) + real'(ry) * real'(ry));
      end while (mag < 300000.0);
      full_op($sformatf("rnd%0d", k), rx, ry);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
